// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the multi-channel memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the search starts at ptr and wraps,
// so the channel just behind the pointer has the lowest priority.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  NUM_CH = 4,
  localparam int GW     = grant_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [GW-1:0]     ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [GW-1:0]     idx,
  output logic              any
);

  function automatic int wrap_idx(input int p, input int off);
    int s;
    s = p + off;
    return (s >= NUM_CH) ? s - NUM_CH : s;
  endfunction

  // First requester found walking upward from the pointer wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!any && req[wrap_idx(int'(ptr), i)]) begin
        any                         = 1'b1;
        idx                         = GW'(wrap_idx(int'(ptr), i));
        gnt[wrap_idx(int'(ptr), i)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates NUM_CH requesters onto one downstream memory port with a
// downstream-ack timeout that reports an error back to the requester.
//
// state | meaning
// IDLE  | waiting for a request; winner's command is registered on exit
// ISSUE | mem_req high, waiting for mem_ack or timeout
// RESP  | one-cycle ch_ack (and ch_err on timeout) to the granted channel
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  NUM_CH         = 4,
  parameter int  DATA_WIDTH     = 256,
  parameter int  ADDR_WIDTH     = 16,
  parameter int  TIMEOUT_CYCLES = 64,
  localparam int GW             = grant_w(NUM_CH)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_CH-1:0]                    ch_req,
  input  logic [NUM_CH-1:0]                    ch_w_en,
  input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    ch_addr,
  input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    ch_wdata,
  output logic [NUM_CH-1:0]                    ch_ack,
  output logic [NUM_CH-1:0]                    ch_err,
  output logic [DATA_WIDTH-1:0]                ch_rdata,
  output logic                                 mem_req,
  output logic                                 mem_w_en,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  input  logic                                 mem_ack,
  input  logic [DATA_WIDTH-1:0]                mem_rdata,
  output logic [GW-1:0]                        grant_id
);

  localparam int              CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_CH-1:0] ONE    = NUM_CH'(1);

  state_t                  state_q, state_d;
  logic [GW-1:0]           ptr_q, ptr_d;
  logic [GW-1:0]           grant_id_q, grant_id_d;
  logic                    w_en_q, w_en_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic [NUM_CH-1:0]       arb_gnt;
  logic [GW-1:0]           arb_idx;
  logic                    arb_any;
  logic                    sel_w;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req (ch_req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // One-hot mux of the winning channel's command.
  always_comb begin
    sel_w     = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_gnt[i]) begin
        sel_w     = ch_w_en[i];
        sel_addr  = ch_addr[i];
        sel_wdata = ch_wdata[i];
      end
    end
  end

  // Next-state, command capture, response capture and timeout counting.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    w_en_d     = w_en_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_id_d = arb_idx;
          w_en_d     = sel_w;
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          cnt_d      = '0;
          err_d      = 1'b0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        // mem_ack takes precedence over a timeout on the same edge.
        if (mem_ack) begin
          rdata_d = w_en_q ? '0 : mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        ptr_d   = (grant_id_q == GW'(NUM_CH - 1)) ? '0 : grant_id_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      w_en_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      w_en_q     <= w_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mem_req   = (state_q == ISSUE);
  assign mem_w_en  = w_en_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign grant_id  = grant_id_q;
  assign ch_rdata  = rdata_q;
  assign ch_ack    = (state_q == RESP) ? (ONE << grant_id_q) : '0;
  assign ch_err    = err_q ? ch_ack : '0;

endmodule
